axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Read-request scheduler in front of the cache-to-AXI bridge's single read port. It shares that port between the instruction cache (requester 0) and the data cache (requester 1). Arbitration is dcache-first, with an anti-starvation override for the icache. The block limits outstanding bursts per requester and can hold reads that hit a line with a pending write. Returned beats are steered back to their owner by ID.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants, taken while icache is waiting, after which icache wins the next arbitration (1..15).
- MAX_OUTST, 2: maximum accepted-but-not-completed bursts per requester (1..7).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- s0_rd_req / s1_rd_req  in  1  read request from icache / dcache.
- s0_rd_type / s1_rd_type  in  3  0=byte, 1=half, 2=word, 4=16-byte line.
- s0_rd_addr / s1_rd_addr  in  32  request address.
- s0_rd_rdy / s1_rd_rdy  out  1  accept. A request transfers when req && rdy in the same cycle.
- s0_ret_valid / s1_ret_valid  out  1  returned beat for this requester.
- s0_ret_last / s1_ret_last  out  1  final beat of the burst.
- s0_ret_data / s1_ret_data  out  32  beat data.
- wr_pending  in  1  downstream write is queued or in flight.
- wr_addr  in  32  address of that write.
- m_rd_req  out  1  request to the bridge.
- m_rd_type  out  3  forwarded type.
- m_rd_addr  out  32  forwarded address.
- m_rd_id  out  4  0 for s0, 1 for s1.
- m_rd_rdy  in  1  bridge accepts m_rd_req.
- m_ret_valid  in  1  returned beat.
- m_ret_last  in  1  final beat.
- m_ret_id  in  4  ID of the returned beat.
- m_ret_data  in  32  returned data.

## Operation
- Two-state FSM: IDLE and ISSUE.
- IDLE -> ISSUE on any accepted request.
- ISSUE -> IDLE when m_rd_rdy is high.
- Eligibility per requester: elig_i = si_rd_req && outst_i < MAX_OUTST && !hazard_i.
- Grant: s1 if elig_1, except s0 wins if elig_0 && starve_cnt == STARVE_LIMIT. Otherwise s0 if elig_0. Otherwise no grant.
- si_rd_rdy = !reset && state==IDLE && grant_i. This is combinational, so at most one rdy is high per cycle.
- On acceptance: register addr, type and ID into m_rd_addr, m_rd_type and m_rd_id, and set m_rd_req.
- In ISSUE: m_rd_req and all m_rd_* fields are held stable until m_rd_rdy. On m_rd_rdy, clear m_rd_req and increment outst[m_rd_id].
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when s1 is accepted while s0_rd_req is high.
  - Clears when s0 is accepted.
  - Holds otherwise.
- Return path:
  - m_ret_id==0 drives s0_ret_*; m_ret_id==1 drives s1_ret_*. This routing is combinational.
  - The other requester's valid and last are 0.
  - Any other ID drives neither requester and is dropped.
  - Data lines always carry m_ret_data.
- outst_i decrements on m_ret_valid && m_ret_last && m_ret_id==i.
- Increment and decrement of the same counter in one cycle leave it unchanged.
- A decrement at 0 holds 0 (no underflow); the beat is still forwarded.
- Counter width is $clog2(MAX_OUTST+1).

## Timing
- Reset values:
  - state IDLE.
  - m_rd_req 0; m_rd_type, m_rd_addr and m_rd_id 0.
  - outst 0; starve_cnt 0.
  - si_rd_rdy 0 while reset is high.
- Request latency: accepted in cycle N, m_rd_req high in cycle N+1. Minimum 2 cycles per issued request.
- Return latency: 0 cycles, purely combinational.
- A requester deasserting req after acceptance has no effect on the issued request.
- Reset during ISSUE drops the pending request and clears all counters; any beats still returning are forwarded but do not decrement counters.

## Configuration
- RD_ARB_WR_HAZARD_EN defined:
  - hazard_i = wr_pending && si_rd_addr[31:4] == wr_addr[31:4].
  - The blocked requester does not win; the other requester may win.
- RD_ARB_WR_HAZARD_EN undefined: hazard_i = 0, and wr_pending and wr_addr are ignored.

## Test plan
- Both requesters request continuously (s1 line @0x1000, s0 line @0x2000), STARVE_LIMIT=4, m_rd_rdy=1, each burst returned immediately -> grant order s1,s1,s1,s1,s0,s1,...
- s1 issues 2 line reads with no returns, MAX_OUTST=2 -> s1_rd_rdy stays 0 and s0 is granted. After one m_ret_last with id=1, s1 is granted again.
- Accept s0 word read @0x80 and hold m_rd_rdy=0 for 5 cycles -> m_rd_req=1 with addr 0x80, id 0, type 2 stable through those cycles. Cleared the cycle after m_rd_rdy.
- m_ret_valid with id=1 and data 0xDEADBEEF, then id=5 -> s1_ret_data=0xDEADBEEF with s1_ret_valid=1. The id=5 beat produces no valid on either requester.
- With the macro defined: wr_pending=1, wr_addr=0x3004, s1 read @0x300C -> s1 blocked. Clearing wr_pending -> granted next cycle. Without the macro -> granted immediately.
- Assert reset in ISSUE with outst0=1 -> m_rd_req=0 and counters 0 the next cycle; a later m_ret_last with id=0 leaves outst0=0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: icache/dcache read scheduler for one AXI read port; define RD_ARB_WR_HAZARD_EN to hold reads that hit a pending write line
module axi_rd_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUTST    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_rd_req,
  input  logic [2:0]  s0_rd_type,
  input  logic [31:0] s0_rd_addr,
  output logic        s0_rd_rdy,
  input  logic        s1_rd_req,
  input  logic [2:0]  s1_rd_type,
  input  logic [31:0] s1_rd_addr,
  output logic        s1_rd_rdy,
  output logic        s0_ret_valid,
  output logic        s0_ret_last,
  output logic [31:0] s0_ret_data,
  output logic        s1_ret_valid,
  output logic        s1_ret_last,
  output logic [31:0] s1_ret_data,
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  output logic        m_rd_req,
  output logic [2:0]  m_rd_type,
  output logic [31:0] m_rd_addr,
  output logic [3:0]  m_rd_id,
  input  logic        m_rd_rdy,
  input  logic        m_ret_valid,
  input  logic        m_ret_last,
  input  logic [3:0]  m_ret_id,
  input  logic [31:0] m_ret_data
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] outst0_q, outst0_d, outst1_q, outst1_d;
  logic [SW-1:0] starve_q, starve_d;
  logic req_q, req_d;
  logic [2:0] type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0] id_q, id_d;
  logic hz0, hz1, elig0, elig1, grant0, grant1, done, inc0, inc1, dec0, dec1;
`ifdef RD_ARB_WR_HAZARD_EN
  assign hz0 = wr_pending && s0_rd_addr[31:4] == wr_addr[31:4];
  assign hz1 = wr_pending && s1_rd_addr[31:4] == wr_addr[31:4];
`else
  logic unused_wr;
  assign unused_wr = ^{wr_pending, wr_addr};
  assign hz0 = 1'b0;
  assign hz1 = 1'b0;
`endif
  // dcache-first grant with icache override once the starvation count saturates
  always_comb begin
    elig0 = s0_rd_req && outst0_q < CW'(MAX_OUTST) && !hz0;
    elig1 = s1_rd_req && outst1_q < CW'(MAX_OUTST) && !hz1;
    grant1 = elig1 && !(elig0 && starve_q == SW'(STARVE_LIMIT));
    grant0 = elig0 && !grant1;
    s0_rd_rdy = !reset && state_q == IDLE && grant0;
    s1_rd_rdy = !reset && state_q == IDLE && grant1;
    done = state_q == ISSUE && m_rd_rdy;
    inc0 = done && id_q == 4'd0;
    inc1 = done && id_q == 4'd1;
    dec0 = m_ret_valid && m_ret_last && m_ret_id == 4'd0;
    dec1 = m_ret_valid && m_ret_last && m_ret_id == 4'd1;
  end
  // next state, held request fields, starvation and outstanding counters
  always_comb begin
    state_d = (s0_rd_rdy || s1_rd_rdy) ? ISSUE : done ? IDLE : state_q;
    req_d = (s0_rd_rdy || s1_rd_rdy) ? 1'b1 : done ? 1'b0 : req_q;
    addr_d = s0_rd_rdy ? s0_rd_addr : s1_rd_rdy ? s1_rd_addr : addr_q;
    type_d = s0_rd_rdy ? s0_rd_type : s1_rd_rdy ? s1_rd_type : type_q;
    id_d = s0_rd_rdy ? 4'd0 : s1_rd_rdy ? 4'd1 : id_q;
    starve_d = s0_rd_rdy ? '0 :
               (s1_rd_rdy && s0_rd_req && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    outst0_d = (inc0 && !dec0) ? outst0_q + 1'b1 :
               (dec0 && !inc0 && outst0_q != '0) ? outst0_q - 1'b1 : outst0_q;
    outst1_d = (inc1 && !dec1) ? outst1_q + 1'b1 :
               (dec1 && !inc1 && outst1_q != '0) ? outst1_q - 1'b1 : outst1_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      type_q   <= '0;
      id_q     <= '0;
      starve_q <= '0;
      outst0_q <= '0;
      outst1_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      type_q   <= type_d;
      id_q     <= id_d;
      starve_q <= starve_d;
      outst0_q <= outst0_d;
      outst1_q <= outst1_d;
    end
  end
  assign m_rd_req = req_q;
  assign m_rd_addr = addr_q;
  assign m_rd_type = type_q;
  assign m_rd_id = id_q;
  assign s0_ret_valid = m_ret_valid && m_ret_id == 4'd0;
  assign s0_ret_last = m_ret_last && m_ret_id == 4'd0;
  assign s1_ret_valid = m_ret_valid && m_ret_id == 4'd1;
  assign s1_ret_last = m_ret_last && m_ret_id == 4'd1;
  assign s0_ret_data = m_ret_data;
  assign s1_ret_data = m_ret_data;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized checks of axi_rd_arbiter against a transaction-level model
module tb_axi_rd_arbiter;
  localparam int LIMIT = 4;
  localparam int MAX = 2;
  logic clk = 0, reset = 1;
  logic s0_rd_req = 0, s1_rd_req = 0, s0_rd_rdy, s1_rd_rdy;
  logic [2:0] s0_rd_type = 0, s1_rd_type = 0, m_rd_type;
  logic [31:0] s0_rd_addr = 0, s1_rd_addr = 0, m_rd_addr, wr_addr = 0, m_ret_data = 0;
  logic s0_ret_valid, s0_ret_last, s1_ret_valid, s1_ret_last;
  logic [31:0] s0_ret_data, s1_ret_data;
  logic wr_pending = 0, m_rd_req, m_rd_rdy = 0, m_ret_valid = 0, m_ret_last = 0;
  logic [3:0] m_rd_id, m_ret_id = 0;
  int checks = 0, errors = 0;
  bit armed = 0, busy = 0;
  int mid = 0, starve = 0, ug, cg, acc;
  int outst[2] = '{0, 0};
  logic [31:0] maddr = 0;
  logic [2:0] mtype = 0;
  int gq[$];
  int exp1[6] = '{1, 1, 1, 1, 0, 1};

  axi_rd_arbiter #(.STARVE_LIMIT(LIMIT), .MAX_OUTST(MAX)) dut (
    .clk(clk), .reset(reset),
    .s0_rd_req(s0_rd_req), .s0_rd_type(s0_rd_type), .s0_rd_addr(s0_rd_addr), .s0_rd_rdy(s0_rd_rdy),
    .s1_rd_req(s1_rd_req), .s1_rd_type(s1_rd_type), .s1_rd_addr(s1_rd_addr), .s1_rd_rdy(s1_rd_rdy),
    .s0_ret_valid(s0_ret_valid), .s0_ret_last(s0_ret_last), .s0_ret_data(s0_ret_data),
    .s1_ret_valid(s1_ret_valid), .s1_ret_last(s1_ret_last), .s1_ret_data(s1_ret_data),
    .wr_pending(wr_pending), .wr_addr(wr_addr),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_id(m_rd_id),
    .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_ret_id(m_ret_id), .m_ret_data(m_ret_data));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  function automatic bit hz(input logic [31:0] a);
`ifdef RD_ARB_WR_HAZARD_EN
    return wr_pending && a[31:4] == wr_addr[31:4];
`else
    return 0;
`endif
  endfunction

  function automatic int grant_now();
    bit e0, e1;
    e0 = s0_rd_req && outst[0] < MAX && !hz(s0_rd_addr);
    e1 = s1_rd_req && outst[1] < MAX && !hz(s1_rd_addr);
    if (e1 && !(e0 && starve == LIMIT)) return 1;
    if (e0) return 0;
    return -1;
  endfunction

  // model: one pending issue slot, per-requester burst counts, starvation count
  initial forever begin
    @(posedge clk);
    if (reset) begin
      busy = 0; mid = 0; maddr = 0; mtype = 0; outst = '{0, 0}; starve = 0; armed = 1;
    end else begin
      ug = grant_now();
      acc = busy ? -1 : ug;
      for (int i = 0; i < 2; i++) begin
        outst[i] += ((busy && m_rd_rdy && mid == i) ? 1 : 0) -
                    ((m_ret_valid && m_ret_last && m_ret_id == i) ? 1 : 0);
        if (outst[i] < 0) outst[i] = 0;
      end
      if (busy && m_rd_rdy) busy = 0;
      if (acc >= 0) begin
        busy = 1; mid = acc;
        maddr = acc == 0 ? s0_rd_addr : s1_rd_addr;
        mtype = acc == 0 ? s0_rd_type : s1_rd_type;
        if (acc == 0) starve = 0;
        else if (s0_rd_req && starve < LIMIT) starve++;
        gq.push_back(acc);
      end
    end
  end

  // compare every cycle at the falling edge
  initial forever begin
    @(negedge clk);
    if (armed) begin
      cg = grant_now();
      chk("s0_rd_rdy", s0_rd_rdy, !reset && !busy && cg == 0);
      chk("s1_rd_rdy", s1_rd_rdy, !reset && !busy && cg == 1);
      chk("m_rd_req", m_rd_req, busy);
      chk("m_rd_addr", m_rd_addr, maddr);
      chk("m_rd_type", m_rd_type, mtype);
      chk("m_rd_id", m_rd_id, mid);
      chk("s0_ret_valid", s0_ret_valid, m_ret_valid && m_ret_id == 0);
      chk("s0_ret_last", s0_ret_last, m_ret_last && m_ret_id == 0);
      chk("s1_ret_valid", s1_ret_valid, m_ret_valid && m_ret_id == 1);
      chk("s1_ret_last", s1_ret_last, m_ret_last && m_ret_id == 1);
      chk("s0_ret_data", s0_ret_data, m_ret_data);
      chk("s1_ret_data", s1_ret_data, m_ret_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1; s0_rd_req = 0; s1_rd_req = 0; m_ret_valid = 0; m_ret_last = 0; wr_pending = 0;
    tick();
    reset = 0;
    gq.delete();
  endtask

  function automatic logic [31:0] raddr();
    return 32'h3000 + 32'($urandom_range(0, 1)) * 32'h10 + 32'($urandom_range(0, 15));
  endfunction

  function automatic logic [2:0] rtype();
    int t = $urandom_range(0, 3);
    return t == 3 ? 3'd4 : 3'(t);
  endfunction

  initial begin
    s0_rd_req = 1; s1_rd_req = 1;
    tick();
    @(negedge clk);
    chk("rst_s0_rdy", s0_rd_rdy, 0);
    chk("rst_s1_rdy", s1_rd_rdy, 0);
    chk("rst_m_req", m_rd_req, 0);
    chk("rst_m_addr", m_rd_addr, 0);
    // starvation order
    reset = 0; gq.delete();
    s0_rd_type = 4; s0_rd_addr = 32'h2000; s1_rd_type = 4; s1_rd_addr = 32'h1000; m_rd_rdy = 1;
    repeat (14) begin
      m_ret_valid = outst[0] > 0 || outst[1] > 0;
      m_ret_last = 1;
      m_ret_id = outst[0] > 0 ? 4'd0 : 4'd1;
      tick();
    end
    chk("grant_count", gq.size() >= 6, 1);
    for (int k = 0; k < 6; k++) if (gq.size() > k) chk("grant_order", gq[k], exp1[k]);
    // outstanding limit
    rst_pulse();
    s1_rd_req = 1; s1_rd_type = 4; s1_rd_addr = 32'h1000; m_rd_rdy = 1;
    repeat (4) tick();
    s0_rd_req = 1; s0_rd_type = 2; s0_rd_addr = 32'h2000;
    @(negedge clk);
    chk("lim_s1_rdy", s1_rd_rdy, 0);
    chk("lim_s0_rdy", s0_rd_rdy, 1);
    tick(); s0_rd_req = 0;
    @(negedge clk);
    chk("lim_id", m_rd_id, 0);
    tick(); m_ret_valid = 1; m_ret_last = 1; m_ret_id = 1;
    @(negedge clk);
    chk("lim_s1_still", s1_rd_rdy, 0);
    tick(); m_ret_valid = 0;
    @(negedge clk);
    chk("lim_s1_again", s1_rd_rdy, 1);
    // held request
    rst_pulse();
    s0_rd_req = 1; s0_rd_type = 2; s0_rd_addr = 32'h80; m_rd_rdy = 0;
    @(negedge clk);
    chk("hold_acc", s0_rd_rdy, 1);
    tick(); s0_rd_req = 0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_req", m_rd_req, 1);
      chk("hold_addr", m_rd_addr, 32'h80);
      chk("hold_id", m_rd_id, 0);
      chk("hold_type", m_rd_type, 2);
      tick();
    end
    m_rd_rdy = 1;
    tick(); m_rd_rdy = 0;
    @(negedge clk);
    chk("hold_clr", m_rd_req, 0);
    // reset during issue with outst0=1
    s0_rd_req = 1; s0_rd_addr = 32'h84;
    tick(); s0_rd_req = 0;
    @(negedge clk);
    chk("ri_req", m_rd_req, 1);
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    chk("ri_req_clr", m_rd_req, 0);
    m_ret_valid = 1; m_ret_last = 1; m_ret_id = 0;
    @(negedge clk);
    chk("ri_fwd", s0_ret_valid, 1);
    tick(); m_ret_valid = 0; s0_rd_req = 1; m_rd_rdy = 1;
    tick(); tick();
    @(negedge clk);
    chk("ri_outst0", s0_rd_rdy, 1);
    tick(); tick(); s0_rd_req = 1;
    @(negedge clk);
    chk("ri_full", s0_rd_rdy, 0);
    s0_rd_req = 0;
    // return routing
    m_ret_valid = 1; m_ret_id = 1; m_ret_last = 0; m_ret_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("ret_data", s1_ret_data, 32'hDEADBEEF);
    chk("ret_v1", s1_ret_valid, 1);
    chk("ret_v0", s0_ret_valid, 0);
    tick(); m_ret_id = 5; m_ret_last = 1;
    @(negedge clk);
    chk("drop_v0", s0_ret_valid, 0);
    chk("drop_v1", s1_ret_valid, 0);
    chk("drop_l1", s1_ret_last, 0);
    tick(); m_ret_valid = 0;
    // write hazard
    rst_pulse();
    wr_pending = 1; wr_addr = 32'h3004; s1_rd_req = 1; s1_rd_addr = 32'h300C; s1_rd_type = 2; m_rd_rdy = 1;
    @(negedge clk);
`ifdef RD_ARB_WR_HAZARD_EN
    chk("hz_block", s1_rd_rdy, 0);
    tick(); wr_pending = 0;
    @(negedge clk);
    chk("hz_release", s1_rd_rdy, 1);
`else
    chk("hz_none", s1_rd_rdy, 1);
`endif
    // random traffic
    rst_pulse();
    repeat (4000) begin
      reset = $urandom_range(0, 199) == 0;
      s0_rd_req = $urandom_range(0, 3) != 0; s0_rd_addr = raddr(); s0_rd_type = rtype();
      s1_rd_req = $urandom_range(0, 3) != 0; s1_rd_addr = raddr(); s1_rd_type = rtype();
      wr_pending = $urandom_range(0, 2) == 0; wr_addr = raddr();
      m_rd_rdy = $urandom_range(0, 2) != 0;
      m_ret_valid = $urandom_range(0, 1); m_ret_last = $urandom_range(0, 1);
      m_ret_id = 4'($urandom_range(0, 2)); m_ret_data = $urandom;
      tick();
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
